// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding IF/ID: owns the PC, fetches over req/ack, emits NOP when empty.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cycles counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {StBoot, StFetch, StWait, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_addr_q;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        out_free;
  logic        load;

  assign pc_inc = pc_q + 32'd4;
  assign target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    out_free = !valid_out || !stall;
    imem_req = 1'b0;
    unique case (state_q)
      StBoot:  imem_req = 1'b0;
      StFetch: imem_req = out_free;
      StWait:  imem_req = 1'b1;
      StDrain: imem_req = 1'b1;
    endcase
    // DRAIN keeps presenting the abandoned address while pc already holds the new target.
    imem_addr = (state_q == StDrain) ? hold_addr_q : pc_q;
    load = imem_req && imem_ack && !redirect &&
           ((state_q == StFetch) || (state_q == StWait));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      hold_addr_q <= RESET_PC;
      instr_out   <= '0;
      pc_out      <= '0;
      valid_out   <= 1'b0;
    end else begin
      if (load) begin
        instr_out <= imem_rdata;
        pc_out    <= pc_inc;
        valid_out <= 1'b1;
        pc_q      <= pc_inc;
      end
      unique case (state_q)
        StBoot:  state_q <= StFetch;
        StFetch: begin
          if (imem_req && !imem_ack) begin
            valid_out   <= 1'b0;
            instr_out   <= '0;
            hold_addr_q <= pc_q;
            state_q     <= redirect ? StDrain : StWait;
          end
        end
        StWait: begin
          // An ack alongside a redirect completes the request, so nothing is left to drain.
          if (imem_ack)      state_q <= StFetch;
          else if (redirect) state_q <= StDrain;
        end
        StDrain: begin
          if (imem_ack) state_q <= StFetch;
        end
      endcase
      if (redirect) begin
        pc_q      <= target;
        valid_out <= 1'b0;
        instr_out <= '0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (load)               perf_fetched      <= perf_fetched + 32'd1;
      if (valid_out && stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus random stall/redirect/ack traffic against a
// transaction-level model tracking the outstanding request rather than FSM states.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
`endif

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .valid_out  (valid_out)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: one optional in-flight request (address + drop flag) and the output slot.
  bit          m_boot, m_pend, m_drop, m_v;
  logic [31:0] m_pc, m_hold, m_instr, m_pco;
  logic [31:0] m_fetched, m_stalls;

  task automatic model_reset();
    m_boot = 1; m_pend = 0; m_drop = 0; m_v = 0;
    m_pc = RESET_PC; m_hold = RESET_PC; m_instr = '0; m_pco = '0;
    m_fetched = '0; m_stalls = '0;
  endtask

  function automatic bit model_req();
    return !m_boot && (m_pend || !m_v || !stall);
  endfunction

  task automatic model_step();
    bit req;
    req = model_req();
    if (m_v && stall) m_stalls++;
    if (m_boot) begin
      m_boot = 0;
    end else if (req && imem_ack) begin
      if (!m_drop && !redirect) begin
        m_instr = imem_rdata;
        m_pc    = m_pc + 32'd4;
        m_pco   = m_pc;
        m_v     = 1;
        m_fetched++;
      end
      m_pend = 0;
      m_drop = 0;
    end else if (req && !m_pend) begin
      m_pend  = 1;
      m_hold  = m_pc;
      m_v     = 0;
      m_instr = '0;
      m_drop  = redirect;
    end else if (req && redirect) begin
      m_drop = 1;
    end
    if (redirect) begin
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_v     = 0;
      m_instr = '0;
    end
  endtask

  task automatic cycle(input bit st, input bit rd, input bit ak, input logic [31:0] tgt);
    @(negedge clk);
    stall = st; redirect = rd; redirect_pc = tgt; imem_ack = ak; imem_rdata = $urandom;
    #1;
    check("imem_req",  32'(imem_req),  32'(model_req()));
    check("imem_addr", imem_addr,      m_pend ? m_hold : m_pc);
    check("instr_out", instr_out,      m_instr);
    check("pc_out",    pc_out,         m_pco);
    check("valid_out", 32'(valid_out), 32'(m_v));
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched,      m_fetched);
    check("perf_stalls",  perf_stall_cycles, m_stalls);
`endif
    @(posedge clk);
    model_step();
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom % 4)
      0:       return RESET_PC + 32'(($urandom % 64) * 4);
      1:       return $urandom;
      2:       return 32'hFFFF_FFF8 + 32'(($urandom % 2) * 4);
      default: return 32'h0040_0100;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; stall = 0; redirect = 0; redirect_pc = '0; imem_ack = 0; imem_rdata = '0;
    model_reset();
    #12;
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_addr",  imem_addr,      RESET_PC);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_instr", instr_out,      32'd0);
    check("rst_pcout", pc_out,         32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Streaming with ack tied high, then stall, delayed ack, redirect during an outstanding request.
    repeat (12) cycle(0, 0, 1, '0);
    repeat (3)  cycle(1, 0, 1, '0);
    repeat (3)  cycle(0, 0, 1, '0);
    repeat (2)  cycle(0, 0, 0, '0);
    repeat (2)  cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);
    cycle(0, 1, 0, 32'h0040_0100);
    repeat (4)  cycle(0, 0, 1, '0);
    cycle(0, 0, 1, '0);
    cycle(1, 1, 1, 32'h0040_0200);
    repeat (3)  cycle(0, 0, 1, '0);

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 10) < 3, ($urandom % 12) == 0, ($urandom % 10) < 6, rand_target());
    end

    // PC wrap at the top of the address space.
    repeat (2) cycle(0, 0, 1, '0);
    cycle(0, 1, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 1, '0);
    #2;
    check("wrap_pcout", pc_out,    32'h0000_0000);
    check("wrap_addr",  imem_addr, 32'h0000_0000);

    // Asynchronous reset while waiting for an ack.
    cycle(0, 0, 1, '0);
    repeat (2) cycle(0, 0, 0, '0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_req",   32'(imem_req),  32'd0);
    check("mid_rst_addr",  imem_addr,      RESET_PC);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    check("mid_rst_instr", instr_out,      32'd0);
    check("mid_rst_pcout", pc_out,         32'd0);
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (6) cycle(0, 0, 1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
